// File: rtl/m_stage_merge_pkg.sv
// m_stage_merge_pkg: shared width, FSM encodings and round-robin constants for the merge stage
package m_stage_merge_pkg;
  localparam int PKT_W = 38;
  // Encodings keep every legal transition from passing through a state that decodes to a handshake output
  typedef enum logic [1:0] {I_IDLE = 2'b00, I_REL_A = 2'b01, I_REL_B = 2'b10} in_state_t;
  typedef enum logic [1:0] {O_IDLE = 2'b00, O_REQ = 2'b01, O_REL = 2'b10} out_state_t;
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;
endpackage

// File: rtl/m_stage_merge_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant; a tie goes to the channel not served last
module rr_arb2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic gnt_a,
  output logic gnt_b
);
  assign gnt_a = req_a & (~req_b | last);
  assign gnt_b = req_b & (~req_a | ~last);
endmodule

// File: rtl/m_stage_merge.sv
// m_stage_merge: merges 4-phase channels a and b into one output through a one-entry packet latch
module m_stage_merge
  import m_stage_merge_pkg::*;
(
  input  logic             CP,
  input  logic             MR,
  input  logic             Send_in_a,
  input  logic [PKT_W-1:0] PACKET_IN_a,
  output logic             Ack_out_a,
  input  logic             Send_in_b,
  input  logic [PKT_W-1:0] PACKET_IN_b,
  output logic             Ack_out_b,
  output logic             Send_out,
  input  logic             Ack_in,
  output logic [PKT_W-1:0] PACKET_OUT
);
  in_state_t        is, is_n;
  out_state_t       os, os_n;
  logic [PKT_W-1:0] dl;
  logic             full, last;
  logic             req_a, req_b, gnt_a, gnt_b, cap, drain;
  assign req_a = Send_in_a & ~full & (is == I_IDLE);
  assign req_b = Send_in_b & ~full & (is == I_IDLE);
  assign cap   = gnt_a | gnt_b;
  assign drain = (os == O_REQ) & Ack_in;
  rr_arb2 u_arb (
    .req_a(req_a),
    .req_b(req_b),
    .last (last),
    .gnt_a(gnt_a),
    .gnt_b(gnt_b)
  );
  always_ff @(posedge CP or posedge MR)
    if (MR) begin
      is <= I_IDLE;
      os <= O_IDLE;
    end else begin
      is <= is_n;
      os <= os_n;
    end
  always_comb begin
    is_n = is == I_IDLE  ? (gnt_a ? I_REL_A : gnt_b ? I_REL_B : I_IDLE) :
           is == I_REL_A ? (Send_in_a ? I_REL_A : I_IDLE) :
           is == I_REL_B ? (Send_in_b ? I_REL_B : I_IDLE) : I_IDLE;
    os_n = os == O_IDLE ? (full ? O_REQ : O_IDLE) :
           os == O_REQ  ? (Ack_in ? O_REL : O_REQ) :
                          (Ack_in ? O_REL : O_IDLE);
  end
  always_comb begin
    Ack_out_a  = is == I_REL_A;
    Ack_out_b  = is == I_REL_B;
    Send_out   = os == O_REQ;
    PACKET_OUT = dl;
  end
  // Capture needs full==0 and drain needs full==1, so the two never collide on one edge
  always_ff @(posedge CP or posedge MR)
    if (MR) begin
      dl   <= '0;
      full <= 1'b0;
      last <= LAST_B;
    end else if (cap) begin
      dl   <= gnt_a ? PACKET_IN_a : PACKET_IN_b;
      full <= 1'b1;
      last <= gnt_b;
    end else if (drain) begin
      full <= 1'b0;
    end
endmodule

// File: tb/tb_m_stage_merge.sv
// tb_m_stage_merge: directed and random merge traffic checked against a packet-level scoreboard
module tb_m_stage_merge;
  import m_stage_merge_pkg::*;
  logic             CP = 1'b0, MR = 1'b1;
  logic             Send_in_a = 1'b0, Send_in_b = 1'b0, Ack_in = 1'b0;
  logic [PKT_W-1:0] PACKET_IN_a = '0, PACKET_IN_b = '0;
  logic             Ack_out_a, Ack_out_b, Send_out;
  logic [PKT_W-1:0] PACKET_OUT;
  int               checks = 0, failures = 0;
  bit               auto_ack = 1'b1, man_ack = 1'b0, hold = 1'b0, rnd_dly = 1'b0, ord_chk = 1'b0;
  int               ack_dly = 0, resp_cnt = 0, n_out = 0;
  int               exp_seq[2];
  logic [PKT_W-1:0] expq[$];
  logic             glog[$];
  logic             pa, pb, pack_a, pack_b, psend, mlast, w;
  logic [PKT_W-1:0] pda, pdb, seen_pkt;
  int               c;

  m_stage_merge dut (
    .CP(CP), .MR(MR),
    .Send_in_a(Send_in_a), .PACKET_IN_a(PACKET_IN_a), .Ack_out_a(Ack_out_a),
    .Send_in_b(Send_in_b), .PACKET_IN_b(PACKET_IN_b), .Ack_out_b(Ack_out_b),
    .Send_out(Send_out), .Ack_in(Ack_in), .PACKET_OUT(PACKET_OUT)
  );

  always #5 CP = ~CP;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Downstream responder: the only writer of Ack_in
  initial forever begin
    @(posedge CP);
    #2;
    if (MR) begin
      Ack_in = 1'b0;
      resp_cnt = 0;
    end else if (!auto_ack) Ack_in = man_ack;
    else if (!Ack_in && Send_out && !hold) begin
      if (resp_cnt >= ack_dly) begin
        Ack_in = 1'b1;
        resp_cnt = 0;
        if (rnd_dly) ack_dly = $urandom_range(0, 3);
      end else resp_cnt++;
    end else if (Ack_in && !Send_out) Ack_in = 1'b0;
  end

  // Packet-level model: a grant must follow round-robin over the requests seen at the deciding edge,
  // the slot holds one packet, and every output packet is the oldest captured one
  always @(negedge CP) begin
    if (MR) begin
      expq.delete();
      glog.delete();
      mlast = 1'b1;
      {pa, pb, pack_a, pack_b, psend} = '0;
    end else begin
      chk("ack_exclusive", {63'd0, Ack_out_a & Ack_out_b}, 64'd0);
      if ((Ack_out_a && !pack_a) || (Ack_out_b && !pack_b)) begin
        w = Ack_out_b;
        chk("grant_had_req", {63'd0, w ? pb : pa}, 64'd1);
        if (pa && pb) chk("grant_rr", {63'd0, w}, {63'd0, !mlast});
        chk("slot_free", expq.size(), 64'd0);
        expq.push_back(w ? pdb : pda);
        glog.push_back(w);
        mlast = w;
      end
      if (Send_out && !psend) begin
        chk("out_pending", expq.size(), 64'd1);
        if (expq.size() > 0) chk("out_data", PACKET_OUT, expq.pop_front());
        n_out++;
        seen_pkt = PACKET_OUT;
        if (ord_chk) begin
          c = int'(PACKET_OUT[PKT_W-1]);
          chk("chan_order", PACKET_OUT[15:0], exp_seq[c]);
          exp_seq[c] = exp_seq[c] + 1;
        end
      end else if (Send_out) chk("out_stable", PACKET_OUT, seen_pkt);
      pa = Send_in_a; pb = Send_in_b; pda = PACKET_IN_a; pdb = PACKET_IN_b;
      pack_a = Ack_out_a; pack_b = Ack_out_b; psend = Send_out;
    end
  end

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic do_reset();
    tick();
    MR = 1'b1;
    Send_in_a = 1'b0;
    Send_in_b = 1'b0;
    #6 MR = 1'b0;
  endtask

  task automatic drive(input logic ch, input logic [PKT_W-1:0] p);
    int n;
    if (ch) begin PACKET_IN_b = p; Send_in_b = 1'b1; end
    else begin PACKET_IN_a = p; Send_in_a = 1'b1; end
    n = 0;
    while ((ch ? Ack_out_b : Ack_out_a) !== 1'b1 && n < 500) begin tick(); n++; end
    chk(ch ? "ack_rise_b" : "ack_rise_a", {63'd0, ch ? Ack_out_b : Ack_out_a}, 64'd1);
    if (ch) Send_in_b = 1'b0; else Send_in_a = 1'b0;
    n = 0;
    while ((ch ? Ack_out_b : Ack_out_a) !== 1'b0 && n < 500) begin tick(); n++; end
    chk(ch ? "ack_fall_b" : "ack_fall_a", {63'd0, ch ? Ack_out_b : Ack_out_a}, 64'd0);
  endtask

  task automatic wait_out(input logic v);
    int n;
    n = 0;
    while (Send_out !== v && n < 200) begin tick(); n++; end
    chk("wait_send_out", {63'd0, Send_out}, {63'd0, v});
  endtask

  initial begin
    int na, nb, n0;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb, n0;
    do_reset();
    chk("rst_ack_a", {63'd0, Ack_out_a}, 64'd0);
    chk("rst_ack_b", {63'd0, Ack_out_b}, 64'd0);
    chk("rst_send", {63'd0, Send_out}, 64'd0);
    chk("rst_dl", PACKET_OUT, 64'd0);
    // 1: asynchronous reset while Send_out is high
    hold = 1'b1;
    tick();
    drive(1'b0, 38'h01_0000_0001);
    wait_out(1'b1);
    tick();
    MR = 1'b1;
    #1;
    chk("t1_send", {63'd0, Send_out}, 64'd0);
    chk("t1_ack_a", {63'd0, Ack_out_a}, 64'd0);
    chk("t1_ack_b", {63'd0, Ack_out_b}, 64'd0);
    chk("t1_dl", PACKET_OUT, 64'd0);
    #5 MR = 1'b0;
    hold = 1'b0;
    tick();
    drive(1'b0, 38'h02_0000_0002);
    wait_out(1'b1);
    chk("t1_next", PACKET_OUT, 64'h02_0000_0002);
    wait_out(1'b0);
    // 2: single packet, latency of two edges
    do_reset();
    ack_dly = 0;
    tick();
    PACKET_IN_a = 38'h12_3456_789A;
    Send_in_a = 1'b1;
    tick();
    chk("t2_ack_a", {63'd0, Ack_out_a}, 64'd1);
    chk("t2_send_early", {63'd0, Send_out}, 64'd0);
    Send_in_a = 1'b0;
    tick();
    chk("t2_send", {63'd0, Send_out}, 64'd1);
    chk("t2_data", PACKET_OUT, 64'h12_3456_789A);
    chk("t2_ack_a_fall", {63'd0, Ack_out_a}, 64'd0);
    tick();
    chk("t2_send_fall", {63'd0, Send_out}, 64'd0);
    repeat (2) tick();
    // 3: simultaneous requests right after reset
    do_reset();
    tick();
    fork
      drive(1'b0, 38'h0A_0000_00A1);
      drive(1'b1, 38'h0B_0000_00B1);
    join
    fork
      drive(1'b0, 38'h0A_0000_00A2);
      drive(1'b1, 38'h0B_0000_00B2);
    join
    repeat (8) tick();
    chk("t3_grants", glog.size(), 64'd4);
    if (glog.size() == 4) begin
      chk("t3_g0", {63'd0, glog[0]}, 64'd0);
      chk("t3_g1", {63'd0, glog[1]}, 64'd1);
      chk("t3_g2", {63'd0, glog[2]}, 64'd0);
      chk("t3_g3", {63'd0, glog[3]}, 64'd1);
    end
    // 4: downstream stalls while b is pending
    do_reset();
    hold = 1'b1;
    tick();
    drive(1'b0, 38'h3F_CAFE_0001);
    wait_out(1'b1);
    fork
      drive(1'b1, 38'h15_BEEF_0002);
      begin
        repeat (10) begin
          tick();
          chk("t4_ack_b", {63'd0, Ack_out_b}, 64'd0);
          chk("t4_dl", PACKET_OUT, 64'h3F_CAFE_0001);
        end
        hold = 1'b0;
      end
    join
    wait_out(1'b1);
    chk("t4_second", PACKET_OUT, 64'h15_BEEF_0002);
    wait_out(1'b0);
    repeat (3) tick();
    // 5: Ack_in drops on the same cycle a new request arrives
    do_reset();
    auto_ack = 1'b0;
    man_ack = 1'b0;
    n0 = n_out;
    tick();
    drive(1'b0, 38'h11_1111_1111);
    wait_out(1'b1);
    man_ack = 1'b1;
    tick();
    chk("t5_drain", {63'd0, Send_out}, 64'd0);
    man_ack = 1'b0;
    PACKET_IN_a = 38'h22_2222_2222;
    Send_in_a = 1'b1;
    tick();
    chk("t5_capture", {63'd0, Ack_out_a}, 64'd1);
    chk("t5_send_low", {63'd0, Send_out}, 64'd0);
    Send_in_a = 1'b0;
    tick();
    chk("t5_send", {63'd0, Send_out}, 64'd1);
    chk("t5_data", PACKET_OUT, 64'h22_2222_2222);
    man_ack = 1'b1;
    tick();
    chk("t5_send_fall", {63'd0, Send_out}, 64'd0);
    man_ack = 1'b0;
    repeat (3) tick();
    chk("t5_count", n_out - n0, 64'd2);
    auto_ack = 1'b1;
    // 6: random traffic on both channels with random downstream delay
    do_reset();
    ord_chk = 1'b1;
    rnd_dly = 1'b1;
    exp_seq[0] = 0;
    exp_seq[1] = 0;
    na = $urandom_range(400, 600);
    nb = 1000 - na;
    n0 = n_out;
    tick();
    fork
      for (int i = 0; i < na; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        drive(1'b0, {1'b0, 21'($urandom), 16'(i)});
      end
      for (int j = 0; j < nb; j++) begin
        repeat ($urandom_range(0, 3)) tick();
        drive(1'b1, {1'b1, 21'($urandom), 16'(j)});
      end
    join
    repeat (20) tick();
    chk("t6_count", n_out - n0, 64'd1000);
    chk("t6_seq_a", exp_seq[0], na);
    chk("t6_seq_b", exp_seq[1], nb);
    chk("t6_empty", expq.size(), 64'd0);
    ord_chk = 1'b0;
    rnd_dly = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
